// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM for the MIPS-lite core: sequences one instruction
// through fetch/decode/execute/memory/writeback and drives all datapath controls.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | load IR, advance PC by 4
// DECODE | classify opcode/funct; NOPs retire here
// EXE    | ALU op for addu/subu/ori/lui
// ALUWB  | write ALU result back to rd (R-type) or rt (ori/lui)
// MADDR  | compute base + sign-extended offset for lw/sw
// MRD    | data memory read for lw
// MWB    | write loaded word back to rt
// MWR    | data memory write for sw
// BRANCH | beq compare; PC takes branch target when zero
// JUMP   | j/jal/jr PC update; jal also links into $31
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             PCWr,
  output logic [1:0]       PCSrc,
  output logic             IRWr,
  output logic             RegWr,
  output logic [1:0]       RegDst,
  output logic [1:0]       WDSel,
  output logic             ALUSrc,
  output logic [2:0]       ALUOp,
  output logic             EXTOp,
  output logic             MemWr,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_ALUWB  = 4'd3,
    S_MADDR  = 4'd4,
    S_MRD    = 4'd5,
    S_MWB    = 4'd6,
    S_MWR    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_rtype, is_addu, is_subu, is_jr;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic cls_alu, cls_mem, cls_jump, cls_imm;

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_addu  = is_rtype && (funct == FN_ADDU);
  assign is_subu  = is_rtype && (funct == FN_SUBU);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);

  assign cls_alu  = is_addu || is_subu || is_ori || is_lui;
  assign cls_mem  = is_lw || is_sw;
  assign cls_jump = is_j || is_jal || is_jr;
  assign cls_imm  = is_ori || is_lui;

  // Raw decode before reset gating of the write strobes.
  logic       pcwr_r, irwr_r, regwr_r, memwr_r, retire_r;
  logic [1:0] pcsrc_r, regdst_r, wdsel_r;
  logic       alusrc_r, extop_r;
  logic [2:0] aluop_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = S_FETCH;
    pcwr_r   = 1'b0;
    pcsrc_r  = 2'b00;
    irwr_r   = 1'b0;
    regwr_r  = 1'b0;
    regdst_r = 2'b00;
    wdsel_r  = 2'b00;
    alusrc_r = 1'b0;
    aluop_r  = 3'b000;
    extop_r  = 1'b0;
    memwr_r  = 1'b0;
    retire_r = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwr_r  = 1'b1;
        pcwr_r  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls_alu)       state_d = S_EXE;
        else if (cls_mem)  state_d = S_MADDR;
        else if (is_beq)   state_d = S_BRANCH;
        else if (cls_jump) state_d = S_JUMP;
        else begin
          state_d  = S_FETCH;
          retire_r = 1'b1;
        end
      end
      S_EXE, S_ALUWB: begin
        if (is_subu)     aluop_r = 3'b001;
        else if (is_ori) aluop_r = 3'b010;
        else if (is_lui) aluop_r = 3'b011;
        else             aluop_r = 3'b000;
        alusrc_r = cls_imm;
        extop_r  = cls_imm;
        if (state_q == S_ALUWB) begin
          regwr_r  = 1'b1;
          regdst_r = is_rtype ? 2'b01 : 2'b00;
          retire_r = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_ALUWB;
        end
      end
      S_MADDR: begin
        alusrc_r = 1'b1;
        state_d  = is_sw ? S_MWR : S_MRD;
      end
      S_MRD: begin
        alusrc_r = 1'b1;
        state_d  = S_MWB;
      end
      S_MWB: begin
        regwr_r  = 1'b1;
        wdsel_r  = 2'b01;
        retire_r = 1'b1;
      end
      S_MWR: begin
        alusrc_r = 1'b1;
        memwr_r  = 1'b1;
        retire_r = 1'b1;
      end
      S_BRANCH: begin
        aluop_r  = 3'b001;
        pcsrc_r  = 2'b01;
        pcwr_r   = zero;
        retire_r = 1'b1;
      end
      S_JUMP: begin
        pcwr_r   = 1'b1;
        pcsrc_r  = is_jr ? 2'b11 : 2'b10;
        retire_r = 1'b1;
        if (is_jal) begin
          regwr_r  = 1'b1;
          regdst_r = 2'b10;
          wdsel_r  = 2'b10;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset abandons the instruction in flight: no architectural write that cycle.
  assign PCWr   = pcwr_r   & ~reset;
  assign IRWr   = irwr_r   & ~reset;
  assign RegWr  = regwr_r  & ~reset;
  assign MemWr  = memwr_r  & ~reset;
  assign retire = retire_r & ~reset;
  assign PCSrc  = pcsrc_r;
  assign RegDst = regdst_r;
  assign WDSel  = wdsel_r;
  assign ALUSrc = alusrc_r;
  assign ALUOp  = aluop_r;
  assign EXTOp  = extop_r;

  assign cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  assign instr_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus a random instruction
// stream, compared cycle by cycle against a per-instruction reference sequence.
module tb_mc_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          zero = 1'b0;
  logic          PCWr, IRWr, RegWr, ALUSrc, EXTOp, MemWr, retire;
  logic [1:0]    PCSrc, RegDst, WDSel;
  logic [2:0]    ALUOp;
  logic [CW-1:0] instr_cnt;
  logic [3:0]    state;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst),
    .WDSel(WDSel), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .EXTOp(EXTOp),
    .MemWr(MemWr), .retire(retire), .instr_cnt(instr_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cnt_m = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];

  // Record: {state, PCWr, PCSrc, IRWr, RegWr, RegDst, WDSel, ALUSrc, ALUOp, EXTOp, MemWr, retire}
  function automatic logic [19:0] mk(input logic [3:0] st, input logic pcwr,
                                     input logic [1:0] pcsrc, input logic irwr,
                                     input logic regwr, input logic [1:0] regdst,
                                     input logic [1:0] wdsel, input logic alusrc,
                                     input logic [2:0] aluop, input logic extop,
                                     input logic memwr, input logic ret);
    return {st, pcwr, pcsrc, irwr, regwr, regdst, wdsel, alusrc, aluop, extop, memwr, ret};
  endfunction

  function automatic logic [19:0] cur();
    return {state, PCWr, PCSrc, IRWr, RegWr, RegDst, WDSel, ALUSrc, ALUOp, EXTOp, MemWr, retire};
  endfunction

  // Expected cycle sequence for one whole instruction, written per mnemonic.
  function automatic void build_exp(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic [19:0] fetch, dec;
    fetch = mk(0, 1, 2'd0, 1, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 0);
    dec   = mk(1, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(fetch);
    if (op == 6'b000000 && fn == 6'b100001) begin        // addu
      exp_q.push_back(dec);
      exp_q.push_back(mk(2, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 0));
      exp_q.push_back(mk(3, 0, 2'd0, 0, 1, 2'd1, 2'd0, 0, 3'd0, 0, 0, 1));
    end else if (op == 6'b000000 && fn == 6'b100011) begin // subu
      exp_q.push_back(dec);
      exp_q.push_back(mk(2, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 3'd1, 0, 0, 0));
      exp_q.push_back(mk(3, 0, 2'd0, 0, 1, 2'd1, 2'd0, 0, 3'd1, 0, 0, 1));
    end else if (op == 6'b000000 && fn == 6'b001000) begin // jr
      exp_q.push_back(dec);
      exp_q.push_back(mk(9, 1, 2'd3, 0, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 1));
    end else if (op == 6'b001101) begin                   // ori
      exp_q.push_back(dec);
      exp_q.push_back(mk(2, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, 3'd2, 1, 0, 0));
      exp_q.push_back(mk(3, 0, 2'd0, 0, 1, 2'd0, 2'd0, 1, 3'd2, 1, 0, 1));
    end else if (op == 6'b001111) begin                   // lui
      exp_q.push_back(dec);
      exp_q.push_back(mk(2, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, 3'd3, 1, 0, 0));
      exp_q.push_back(mk(3, 0, 2'd0, 0, 1, 2'd0, 2'd0, 1, 3'd3, 1, 0, 1));
    end else if (op == 6'b100011) begin                   // lw
      exp_q.push_back(dec);
      exp_q.push_back(mk(4, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, 3'd0, 0, 0, 0));
      exp_q.push_back(mk(5, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, 3'd0, 0, 0, 0));
      exp_q.push_back(mk(6, 0, 2'd0, 0, 1, 2'd0, 2'd1, 0, 3'd0, 0, 0, 1));
    end else if (op == 6'b101011) begin                   // sw
      exp_q.push_back(dec);
      exp_q.push_back(mk(4, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, 3'd0, 0, 0, 0));
      exp_q.push_back(mk(7, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, 3'd0, 0, 1, 1));
    end else if (op == 6'b000100) begin                   // beq
      exp_q.push_back(dec);
      exp_q.push_back(mk(8, z, 2'd1, 0, 0, 2'd0, 2'd0, 0, 3'd1, 0, 0, 1));
    end else if (op == 6'b000010) begin                   // j
      exp_q.push_back(dec);
      exp_q.push_back(mk(9, 1, 2'd2, 0, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 1));
    end else if (op == 6'b000011) begin                   // jal
      exp_q.push_back(dec);
      exp_q.push_back(mk(9, 1, 2'd2, 0, 1, 2'd2, 2'd2, 0, 3'd0, 0, 0, 1));
    end else begin                                        // NOP retires in DECODE
      exp_q.push_back(mk(1, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 0, 0, 1));
    end
  endfunction

  // Entered ~1ns into a FETCH cycle; leaves ~1ns into the next FETCH cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op; funct = fn; zero = z;
    #1;
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      obs_q.push_back(cur());
      if (retire === 1'b1) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    build_exp(op, fn, z);
    cnt_m = (cnt_m + 1) % (1 << CW);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (instr_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", instr_cnt); end
    total++; if ({PCWr, IRWr, RegWr, MemWr, retire} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=00000", {PCWr, IRWr, RegWr, MemWr, retire});
    end
    reset = 1'b0;
    #1;
    total++; if ({IRWr, PCWr, PCSrc} !== 4'b1100) begin
      bad++; $display("FAIL first_fetch got=%b exp=1100", {IRWr, PCWr, PCSrc});
    end
    cnt_m = 0;
  endtask

  task automatic test_addu();
    run_instr(6'b000000, 6'b100001, 1'b0);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL addu_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL addu_cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (instr_cnt !== CW'(cnt_m)) begin bad++; $display("FAIL addu_cnt got=%0d exp=%0d", instr_cnt, cnt_m); end
  endtask

  task automatic test_ori_lw();
    logic [5:0] ops [2];
    ops[0] = 6'b001101; ops[1] = 6'b100011;
    for (int k = 0; k < 2; k++) begin
      run_instr(ops[k], 6'($urandom), 1'($urandom));
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL orilw%0d_len got=%0d exp=%0d", k, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL orilw%0d_cyc%0d got=%h exp=%h", k, i, obs_q[i], exp_q[i]); end
      end
    end
    total++; if (instr_cnt !== CW'(cnt_m)) begin bad++; $display("FAIL orilw_cnt got=%0d exp=%0d", instr_cnt, cnt_m); end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      run_instr(6'b000100, 6'($urandom), (k == 0));
      total++; if (obs_q.size() != 3) begin bad++; $display("FAIL beq%0d_len got=%0d exp=3", k, obs_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL beq%0d_cyc%0d got=%h exp=%h", k, i, obs_q[i], exp_q[i]); end
      end
      total++; if (instr_cnt !== CW'(cnt_m)) begin bad++; $display("FAIL beq%0d_cnt got=%0d exp=%0d", k, instr_cnt, cnt_m); end
    end
  endtask

  task automatic test_jal_jr();
    logic [5:0] ops [2];
    logic [5:0] fns [2];
    ops[0] = 6'b000011; fns[0] = 6'($urandom);
    ops[1] = 6'b000000; fns[1] = 6'b001000;
    for (int k = 0; k < 2; k++) begin
      run_instr(ops[k], fns[k], 1'($urandom));
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL jump%0d_len got=%0d exp=%0d", k, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL jump%0d_cyc%0d got=%h exp=%h", k, i, obs_q[i], exp_q[i]); end
      end
    end
    total++; if (instr_cnt !== CW'(cnt_m)) begin bad++; $display("FAIL jump_cnt got=%0d exp=%0d", instr_cnt, cnt_m); end
  endtask

  task automatic test_reset_in_mwr();
    bit reached = 0;
    opcode = 6'b101011; funct = 6'($urandom); zero = 1'($urandom);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (state === 4'd7) begin reached = 1; break; end
      @(posedge clk); #1;
    end
    total++; if (!reached) begin bad++; $display("FAIL sw_reach_mwr got=%0d exp=7", state); end
    total++; if (MemWr !== 1'b1) begin bad++; $display("FAIL sw_mwr_memwr got=%b exp=1", MemWr); end
    reset = 1'b1;
    #1;
    total++; if ({MemWr, retire} !== 2'b00) begin bad++; $display("FAIL sw_rst_strobes got=%b exp=00", {MemWr, retire}); end
    @(posedge clk); #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL sw_rst_state got=%0d exp=0", state); end
    total++; if (instr_cnt !== '0) begin bad++; $display("FAIL sw_rst_cnt got=%0d exp=0", instr_cnt); end
    reset = 1'b0;
    cnt_m = 0;
    #1;
  endtask

  task automatic test_nop();
    run_instr(6'b111111, 6'($urandom), 1'($urandom));
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL nop_len got=%0d exp=2", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL nop_cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL nop_back_fetch got=%0d exp=0", state); end
    total++; if (instr_cnt !== CW'(cnt_m)) begin bad++; $display("FAIL nop_cnt got=%0d exp=%0d", instr_cnt, cnt_m); end
  endtask

  // Back-to-back random stream; narrow counter makes it wrap several times.
  task automatic test_back_to_back();
    logic [5:0] op, fn;
    for (int n = 0; n < 60; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 11))
        0:  begin op = 6'b000000; fn = 6'b100001; end
        1:  begin op = 6'b000000; fn = 6'b100011; end
        2:  begin op = 6'b000000; fn = 6'b001000; end
        3:  op = 6'b000000;
        4:  op = 6'b001101;
        5:  op = 6'b001111;
        6:  op = 6'b100011;
        7:  op = 6'b101011;
        8:  op = 6'b000100;
        9:  op = 6'b000010;
        10: op = 6'b000011;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fn, 1'($urandom));
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_len op=%b fn=%b got=%0d exp=%0d", n, op, fn, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_cyc%0d op=%b fn=%b got=%h exp=%h", n, i, op, fn, obs_q[i], exp_q[i]); end
      end
      total++; if (instr_cnt !== CW'(cnt_m)) begin bad++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", n, instr_cnt, cnt_m); end
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_ori_lw();
    test_beq();
    test_jal_jr();
    test_reset_in_mwr();
    test_nop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
